// File: rtl/vend_mmio_pkg.sv
// Shared constants, state encoding and coin helpers for the vending MMIO port.
package vend_mmio_pkg;

   localparam logic [31:0] STATUS_OFS  = 32'h0000_0000;
   localparam logic [31:0] COMMAND_OFS = 32'h0000_0004;

   localparam logic [7:0] NICKEL_C  = 8'd5;
   localparam logic [7:0] DIME_C    = 8'd10;
   localparam logic [7:0] QUARTER_C = 8'd25;

   localparam int STAT_REFUND_BIT = 31;
   localparam int STAT_BUSY_BIT   = 30;
   localparam int STAT_ERROR_BIT  = 29;

   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VEND_ON = 2'd1,
      COIN_ON = 2'd2,
      GAP     = 2'd3
   } dispense_state_t;

   typedef enum logic [1:0] {
      COIN_NICKEL  = 2'd0,
      COIN_DIME    = 2'd1,
      COIN_QUARTER = 2'd2
   } coin_t;

   // Largest coin that fits; callers only ask when remaining >= NICKEL_C.
   function automatic coin_t pick_coin(input logic [7:0] remaining);
      if (remaining >= QUARTER_C)   return COIN_QUARTER;
      else if (remaining >= DIME_C) return COIN_DIME;
      else                          return COIN_NICKEL;
   endfunction

   function automatic logic [7:0] coin_value(input coin_t c);
      case (c)
         COIN_QUARTER: return QUARTER_C;
         COIN_DIME:    return DIME_C;
         default:      return NICKEL_C;
      endcase
   endfunction

   function automatic logic [7:0] round_down5(input logic [7:0] amt);
      return amt - (amt % 8'd5);
   endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Vend / change-coin pulse sequencer: one vend pulse then greedy coin pulses,
// each followed by a gap, with a single shared down-counter for pulse and gap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not busy, waiting for an accepted command
//   VEND_ON | vend output high, counting PULSE_CYCLES
//   COIN_ON | one coin output high, counting PULSE_CYCLES
//   GAP     | all outputs low, counting GAP_CYCLES
module vend_change_dispenser
   import vend_mmio_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_vend,
   input  logic [7:0] i_amount,
   output logic       o_busy,
   output logic       o_vend,
   output logic       o_nickel,
   output logic       o_dime,
   output logic       o_quarter
);

   localparam int MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW    = $clog2(MAX_C + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

   dispense_state_t r_state;
   logic [7:0]      r_remaining;
   logic [CW-1:0]   r_count;
   logic            r_busy;
   logic            r_vend;
   logic            r_nickel;
   logic            r_dime;
   logic            r_quarter;

   logic [7:0] w_start_amt;
   logic [7:0] w_launch_amt;
   coin_t      w_coin;

   // One coin selector serves both the first coin of a command and later ones.
   assign w_start_amt  = round_down5(i_amount);
   assign w_launch_amt = (r_state == IDLE) ? w_start_amt : r_remaining;
   assign w_coin       = pick_coin(w_launch_amt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= 8'd0;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_vend      <= 1'b0;
         r_nickel    <= 1'b0;
         r_dime      <= 1'b0;
         r_quarter   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start && i_vend) begin
                  r_state     <= VEND_ON;
                  r_busy      <= 1'b1;
                  r_vend      <= 1'b1;
                  r_count     <= PULSE_LOAD;
                  r_remaining <= w_start_amt;
               end else if (i_start && (w_start_amt >= NICKEL_C)) begin
                  r_state     <= COIN_ON;
                  r_busy      <= 1'b1;
                  r_count     <= PULSE_LOAD;
                  r_remaining <= w_start_amt - coin_value(w_coin);
                  r_nickel    <= (w_coin == COIN_NICKEL);
                  r_dime      <= (w_coin == COIN_DIME);
                  r_quarter   <= (w_coin == COIN_QUARTER);
               end
            end
            VEND_ON, COIN_ON: begin
               if (r_count == '0) begin
                  r_state   <= GAP;
                  r_count   <= GAP_LOAD;
                  r_vend    <= 1'b0;
                  r_nickel  <= 1'b0;
                  r_dime    <= 1'b0;
                  r_quarter <= 1'b0;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            GAP: begin
               if (r_count != '0) begin
                  r_count <= r_count - 1'b1;
               end else if (r_remaining >= NICKEL_C) begin
                  r_state     <= COIN_ON;
                  r_count     <= PULSE_LOAD;
                  r_remaining <= r_remaining - coin_value(w_coin);
                  r_nickel    <= (w_coin == COIN_NICKEL);
                  r_dime      <= (w_coin == COIN_DIME);
                  r_quarter   <= (w_coin == COIN_QUARTER);
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_vend    = r_vend;
   assign o_nickel  = r_nickel;
   assign o_dime    = r_dime;
   assign o_quarter = r_quarter;

endmodule

// File: rtl/vend_mmio_port.sv
// CPU-bus vending responder: STATUS word with coin credit and sticky flags,
// COMMAND register that launches the vend/change dispenser.
module vend_mmio_port
   import vend_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int          PULSE_CYCLES = 2,
   parameter int          GAP_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_address,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic [1:0]  mem_read_write_size,
   input  logic [31:0] mem_write_value,
   output logic [31:0] mem_read_value,
   input  logic        nickel,
   input  logic        dime,
   input  logic        quarter,
   input  logic        refund,
   output logic        vend,
   output logic        nickel_out,
   output logic        dime_out,
   output logic        quarter_out
);

   localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + STATUS_OFS;
   localparam logic [31:0] COMMAND_ADDR = BASE_ADDR + COMMAND_OFS;

   logic [3:0] r_in_s;
   logic [3:0] r_in_p;
   logic [7:0] r_credit;
   logic       r_refund_flag;
   logic       r_error_flag;

   logic       w_status_hit;
   logic       w_cmd_hit;
   logic       w_status_rd;
   logic       w_cmd_wr;
   logic       w_accept;
   logic       w_busy;
   logic [3:0] w_edge;
   logic [7:0] w_add;
   logic [7:0] w_base;
   logic [8:0] w_sum;

   assign w_status_hit = (mem_address[31:2] == STATUS_ADDR[31:2]);
   assign w_cmd_hit    = (mem_address[31:2] == COMMAND_ADDR[31:2]);
   assign w_status_rd  = mem_read_enable & w_status_hit;
   assign w_cmd_wr     = mem_write_enable & w_cmd_hit & (mem_read_write_size == SIZE_WORD);
   assign w_accept     = w_cmd_wr & ~w_busy;

   // Bit order {refund, quarter, dime, nickel}; r_in_p is the previous sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_s <= 4'b0;
         r_in_p <= 4'b0;
      end else begin
         r_in_s <= {refund, quarter, dime, nickel};
         r_in_p <= r_in_s;
      end
   end

   assign w_edge = r_in_s & ~r_in_p;
   assign w_add  = (w_edge[0] ? NICKEL_C  : 8'd0)
                 + (w_edge[1] ? DIME_C    : 8'd0)
                 + (w_edge[2] ? QUARTER_C : 8'd0);

   // A STATUS load clears first; this cycle's coins land on the cleared value.
   assign w_base = w_status_rd ? 8'd0 : r_credit;
   assign w_sum  = {1'b0, w_base} + {1'b0, w_add};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credit      <= 8'd0;
         r_refund_flag <= 1'b0;
         r_error_flag  <= 1'b0;
      end else begin
         r_credit      <= w_sum[8] ? 8'hFF : w_sum[7:0];
         r_refund_flag <= (r_refund_flag & ~w_status_rd) | w_edge[3];
         r_error_flag  <= (r_error_flag & ~w_status_rd) | (w_cmd_wr & w_busy);
      end
   end

   always_comb begin
      mem_read_value = 32'h0;
      if (w_status_hit) begin
         mem_read_value[7:0]             = r_credit;
         mem_read_value[STAT_REFUND_BIT] = r_refund_flag;
         mem_read_value[STAT_BUSY_BIT]   = w_busy;
         mem_read_value[STAT_ERROR_BIT]  = r_error_flag;
      end
   end

   vend_change_dispenser #(
      .PULSE_CYCLES (PULSE_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
   ) u_dispenser (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_accept),
      .i_vend    (mem_write_value[31]),
      .i_amount  (mem_write_value[7:0]),
      .o_busy    (w_busy),
      .o_vend    (vend),
      .o_nickel  (nickel_out),
      .o_dime    (dime_out),
      .o_quarter (quarter_out)
   );

endmodule

// File: tb/tb_vend_mmio_port.sv
// Self-checking bench for vend_mmio_port: credit/flag model plus expected
// pulse traces built from the greedy change rule.
module tb_vend_mmio_port;

   localparam logic [31:0] ST  = 32'h0000_1000;
   localparam logic [31:0] CMD = 32'h0000_1004;
   localparam int P = 2;
   localparam int G = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_address;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [1:0]  mem_read_write_size;
   logic [31:0] mem_write_value;
   logic [31:0] mem_read_value;
   logic        nickel, dime, quarter, refund;
   logic        vend, nickel_out, dime_out, quarter_out;

   always #5 clk = ~clk;

   vend_mmio_port #(
      .BASE_ADDR    (32'h0000_1000),
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .mem_address         (mem_address),
      .mem_read_enable     (mem_read_enable),
      .mem_write_enable    (mem_write_enable),
      .mem_read_write_size (mem_read_write_size),
      .mem_write_value     (mem_write_value),
      .mem_read_value      (mem_read_value),
      .nickel              (nickel),
      .dime                (dime),
      .quarter             (quarter),
      .refund              (refund),
      .vend                (vend),
      .nickel_out          (nickel_out),
      .dime_out            (dime_out),
      .quarter_out         (quarter_out)
   );

   int       total  = 0;
   int       passed = 0;
   int       m_credit;
   bit       m_refund;
   bit       m_error;
   bit [3:0] m_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // 0 none, 1 vend, 2 nickel, 3 dime, 4 quarter, 7 more than one output high
   function automatic int out_code();
      int n;
      n = int'(vend) + int'(nickel_out) + int'(dime_out) + int'(quarter_out);
      if (n > 1)       return 7;
      if (vend)        return 1;
      if (nickel_out)  return 2;
      if (dime_out)    return 3;
      if (quarter_out) return 4;
      return 0;
   endfunction

   function automatic logic [31:0] exp_status(input bit busy);
      return {m_refund, busy, m_error, 21'b0, 8'(m_credit)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive levels {refund, quarter, dime, nickel} for one cycle, crediting edges.
   task automatic drive_coins(input bit [3:0] lv);
      bit [3:0] e;
      {refund, quarter, dime, nickel} = lv;
      e = lv & ~m_prev;
      m_prev = lv;
      m_credit = m_credit + (e[0] ? 5 : 0) + (e[1] ? 10 : 0) + (e[2] ? 25 : 0);
      if (m_credit > 255) m_credit = 255;
      if (e[3]) m_refund = 1'b1;
      tick();
   endtask

   task automatic settle();
      for (int k = 0; k < 3; k++) drive_coins(4'b0000);
   endtask

   task automatic status_read(input string tag);
      mem_address = ST;
      mem_read_enable = 1'b1;
      #2;
      check(tag, mem_read_value, exp_status(1'b0));
      tick();
      mem_read_enable = 1'b0;
      m_credit = 0;
      m_refund = 1'b0;
      m_error = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [31:0] exp);
      mem_address = ST;
      #1;
      check(tag, mem_read_value, exp);
   endtask

   task automatic run_cmd(input string tag, input logic [31:0] data, input logic [1:0] size,
                          input int inj_at, input logic [31:0] inj_data, input int rd_at);
      int items[$];
      int amt, len, errs, bcnt, bexp, expc;
      bit acc, bsamp;
      items = {};
      amt = int'(data[7:0]);
      amt = amt - (amt % 5);
      acc = (size == 2'b10) && (data[31] || amt >= 5);
      if (acc) begin
         if (data[31]) items.push_back(1);
         while (amt >= 25) begin items.push_back(4); amt -= 25; end
         while (amt >= 10) begin items.push_back(3); amt -= 10; end
         while (amt >= 5)  begin items.push_back(2); amt -= 5;  end
      end
      len = items.size() * (P + G);
      mem_address = CMD;
      mem_write_value = data;
      mem_read_write_size = size;
      mem_write_enable = 1'b1;
      tick();
      mem_write_enable = 1'b0;
      mem_address = ST;
      errs = 0;
      bcnt = 0;
      bexp = len;
      for (int i = 0; i < len + 4; i++) begin
         if (i == inj_at) begin
            mem_address = CMD;
            mem_write_value = inj_data;
            mem_read_write_size = 2'b10;
            mem_write_enable = 1'b1;
            if (i < len) bexp--;
         end
         if (i == rd_at) mem_read_enable = 1'b1;
         #3;
         expc = (i < len && (i % (P + G)) < P) ? items[i / (P + G)] : 0;
         if (out_code() != expc) errs++;
         if (i != inj_at) begin
            bsamp = mem_read_value[30];
            if (bsamp) bcnt++;
            if (bsamp != (i < len)) errs++;
         end
         if (i == rd_at) check({tag, " status"}, mem_read_value, exp_status(i < len));
         tick();
         mem_write_enable = 1'b0;
         mem_read_enable = 1'b0;
         mem_address = ST;
         if (i == inj_at && i < len) m_error = 1'b1;
         if (i == rd_at) begin
            m_credit = 0;
            m_refund = 1'b0;
            m_error = 1'b0;
         end
      end
      check({tag, " trace"}, errs, 0);
      check({tag, " busy cycles"}, bcnt, bexp);
   endtask

   initial begin
      int pre, n, quiet;
      reset = 1'b1;
      mem_address = ST;
      mem_read_enable = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_write_size = 2'b10;
      mem_write_value = 32'h0;
      {refund, quarter, dime, nickel} = 4'b0;
      m_credit = 0; m_refund = 1'b0; m_error = 1'b0; m_prev = 4'b0;
      #1;
      check("reset outputs", {28'b0, vend, nickel_out, dime_out, quarter_out}, 32'h0);
      check("reset status", mem_read_value, 32'h0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // nickel held 3 cycles, dime pulse, quarter+nickel together
      drive_coins(4'b0001); drive_coins(4'b0001); drive_coins(4'b0001);
      drive_coins(4'b0000);
      drive_coins(4'b0010); drive_coins(4'b0000);
      drive_coins(4'b0101); drive_coins(4'b0000);
      settle();
      check("coin model", m_credit, 45);
      status_read("credit 2D");
      status_read("credit cleared");

      // edge in cycle t visible at t+2
      {refund, quarter, dime, nickel} = 4'b0001;
      m_prev = 4'b0001;
      tick();
      peek("latency t+1", 32'h0);
      tick();
      peek("latency t+2", 32'h5);
      m_credit = 5;
      settle();

      // coin accumulating in the same cycle as the clearing load
      pre = m_credit;
      {refund, quarter, dime, nickel} = 4'b0010;
      m_prev = 4'b0010;
      tick();
      mem_address = ST;
      mem_read_enable = 1'b1;
      #2;
      check("load with coin", mem_read_value, 32'(pre));
      tick();
      mem_read_enable = 1'b0;
      m_credit = 10; m_refund = 1'b0; m_error = 1'b0;
      settle();
      status_read("coin after clear");

      // saturation and refund
      for (int k = 0; k < 11; k++) begin
         drive_coins(4'b0100);
         drive_coins(4'b0000);
      end
      settle();
      peek("saturate", 32'h0000_00FF);
      drive_coins(4'b1000); drive_coins(4'b0000);
      settle();
      status_read("refund flag");

      // randomized coin activity
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(4, 12);
         for (int k = 0; k < n; k++) drive_coins(4'($urandom_range(0, 15)));
         settle();
         status_read("random credit");
      end

      run_cmd("vend 40c", 32'h8000_0028, 2'b10, -1, 32'h0, -1);
      run_cmd("zero cmd", 32'h0000_0000, 2'b10, -1, 32'h0, -1);
      run_cmd("7c change", 32'h0000_0007, 2'b10, -1, 32'h0, -1);
      run_cmd("byte store", 32'h8000_0028, 2'b00, -1, 32'h0, -1);
      run_cmd("busy store", 32'h8000_0028, 2'b10, 5, 32'h8000_0000 | $urandom, 9);
      status_read("error cleared");
      run_cmd("last gap store", 32'h0000_0005, 2'b10, 3, 32'h8000_0019, -1);
      status_read("last gap error");

      for (int r = 0; r < 6; r++) begin
         run_cmd("random cmd", $urandom, 2'b10, -1, 32'h0, -1);
      end

      // reset during a dime pulse aborts the dispense
      mem_address = CMD;
      mem_write_value = 32'h0000_000F;
      mem_read_write_size = 2'b10;
      mem_write_enable = 1'b1;
      tick();
      mem_write_enable = 1'b0;
      mem_address = ST;
      #3;
      check("pre-reset dime", out_code(), 3);
      #2;
      reset = 1'b1;
      #1;
      check("reset mid pulse", {28'b0, vend, nickel_out, dime_out, quarter_out}, 32'h0);
      check("reset mid status", mem_read_value, 32'h0);
      m_credit = 0; m_refund = 1'b0; m_error = 1'b0; m_prev = 4'b0;
      tick(); tick();
      reset = 1'b0;
      quiet = 0;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (out_code() != 0 || mem_read_value[30]) quiet++;
         tick();
      end
      check("no pulses after reset", quiet, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
